// File: rtl/mux_scan_pkg.sv
// Shared definitions for the round-robin scan multiplexer.
//   CH_W        width of a channel code
//   NUM_CH_MAX  number of physical channel inputs
//   state_t     scan FSM states
//   lowest_set  lowest set bit of a channel-enable vector (0 if none set)
package mux_scan_pkg;

  localparam int CH_W       = 3;
  localparam int NUM_CH_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH_MAX-1:0] em);
    logic [CH_W-1:0] r;
    r = '0;
    // Walk downward so the last hit is the lowest index.
    for (int i = NUM_CH_MAX - 1; i >= 0; i--) begin
      if (em[i]) r = CH_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin successor search.
// Ports:
//   cur       current channel (always < NUM_CH in normal operation)
//   em        effective channel-enable vector
//   nxt       next enabled channel searching upward from cur+1 modulo NUM_CH
//             (cur itself is the last candidate, so a lone channel selects itself)
//   wrap      successor is at or below cur, i.e. a new scan pass begins
//   none_set  em is all zero; nxt then holds cur
module rr_next_ch
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic [CH_W-1:0]       cur,
  input  logic [NUM_CH_MAX-1:0] em,
  output logic [CH_W-1:0]       nxt,
  output logic                  wrap,
  output logic                  none_set
);

  localparam int CW1 = CH_W + 1;

  logic [CW1-1:0] cand;
  logic           found;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, cur} + CW1'(i);
      if (cand >= CW1'(NUM_CH)) cand = cand - CW1'(NUM_CH);
      if (!found && em[cand[CH_W-1:0]]) begin
        nxt   = cand[CH_W-1:0];
        found = 1'b1;
      end
    end
    none_set = ~|em;
    wrap     = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_8_1_scan.sv
// Registered 8-to-1 time-division multiplexer with round-robin scan.
// Dwells DWELL clocks on each enabled channel and registers the selected
// input onto y, with valid and frame_start strobes one cycle behind sel.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           scan enable
//   mask[7:0]    per-channel enable; bits >= NUM_CH ignored
//   x0..x7       channel inputs
//   sel[2:0]     channel currently sampled (registered)
//   y            registered sample of the selected channel
//   valid        y holds a sample from an active scan
//   frame_start  pulse with the first valid sample of each scan pass
//   busy         FSM is in SCAN
//
// state | meaning
// IDLE  | not scanning; sel holds its last value
// SCAN  | dwelling on sel, advancing every DWELL clocks
module mux_8_1_scan
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH  = 6,
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0]      mask,
  input  logic            x0,
  input  logic            x1,
  input  logic            x2,
  input  logic            x3,
  input  logic            x4,
  input  logic            x5,
  input  logic            x6,
  input  logic            x7,
  output logic [CH_W-1:0] sel,
  output logic            y,
  output logic            valid,
  output logic            frame_start,
  output logic            busy
);

  localparam logic [NUM_CH_MAX-1:0] EM_MASK    = NUM_CH_MAX'((1 << NUM_CH) - 1);
  localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t                state, state_nxt;
  logic [CH_W-1:0]       sel_nxt;
  logic [CH_W-1:0]       rr_ch;
  logic [DWELL_W-1:0]    cnt, cnt_nxt;
  logic                  wrap_f, wrap_nxt;
  logic                  rr_wrap, rr_none;
  logic [NUM_CH_MAX-1:0] em;
  logic [NUM_CH_MAX-1:0] xv;
  logic                  at_last;

  assign em      = mask & EM_MASK;
  assign xv      = {x7, x6, x5, x4, x3, x2, x1, x0};
  assign at_last = (cnt == DWELL_LAST);
  assign busy    = (state == SCAN);

  rr_next_ch #(.NUM_CH(NUM_CH)) u_rr (
    .cur      (sel),
    .em       (em),
    .nxt      (rr_ch),
    .wrap     (rr_wrap),
    .none_set (rr_none)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    wrap_nxt  = wrap_f;
    case (state)
      IDLE: begin
        if (en && !rr_none) begin
          state_nxt = SCAN;
          sel_nxt   = lowest_set(em);
          cnt_nxt   = '0;
          wrap_nxt  = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          // The pass marker is consumed by the first sample of a dwell;
          // an advance on the same edge reloads it.
          if (cnt == '0) wrap_nxt = 1'b0;
          if (at_last) begin
            cnt_nxt = '0;
            if (rr_none) begin
              state_nxt = IDLE;
            end else begin
              sel_nxt  = rr_ch;
              wrap_nxt = rr_wrap;
            end
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      wrap_f <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      wrap_f <= wrap_nxt;
    end
  end

  // Output stage lags sel by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      y           <= 1'b0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      y           <= (int'(sel) < NUM_CH) ? xv[sel] : 1'b0;
      valid       <= (state == SCAN);
      frame_start <= (state == SCAN) && (cnt == '0) && wrap_f;
    end
  end

endmodule

// File: tb/tb_mux_8_1_scan.sv
module tb_mux_8_1_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [7:0] xv;
  logic [2:0] sel;
  logic       y, valid, frame_start, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_8_1_scan #(.NUM_CH(6), .DWELL(4), .DWELL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mask        (mask),
    .x0          (xv[0]),
    .x1          (xv[1]),
    .x2          (xv[2]),
    .x3          (xv[3]),
    .x4          (xv[4]),
    .x5          (xv[5]),
    .x6          (xv[6]),
    .x7          (xv[7]),
    .sel         (sel),
    .y           (y),
    .valid       (valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    mask = 8'hFF;
    xv   = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({sel, y, valid, frame_start, busy} !== 7'd0) begin
        errors++;
        $display("FAIL reset c%0d: got sel=%0d y=%b valid=%b fs=%b busy=%b, need all 0",
                 c, sel, y, valid, frame_start, busy);
      end
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  // Generic expectation after the k-th edge of a scan started at k=0:
  // sel steps every 4 clocks through the channel list, outputs lag by one.
  task automatic test_full_scan();
    logic [2:0] e_sel, p_sel;
    logic       e_valid, e_fs;
    do_reset();
    mask = 8'h3F;
    xv   = 8'h09;
    en   = 1'b1;
    p_sel = 3'd0;
    for (int k = 0; k < 52; k++) begin
      tick();
      e_sel   = 3'((k / 4) % 6);
      e_valid = (k >= 1);
      e_fs    = (k >= 1) && (((k - 1) % 24) == 0);
      checks++;
      if ({sel, valid, frame_start, busy} !== {e_sel, e_valid, e_fs, 1'b1}) begin
        errors++;
        $display("FAIL full_scan k%0d: got sel=%0d valid=%b fs=%b busy=%b, need sel=%0d valid=%b fs=%b busy=1",
                 k, sel, valid, frame_start, busy, e_sel, e_valid, e_fs);
      end
      if (e_valid) begin
        checks++;
        if (y !== xv[p_sel]) begin
          errors++;
          $display("FAIL full_scan_y k%0d: got y=%b, need %b", k, y, xv[p_sel]);
        end
      end
      p_sel = e_sel;
    end
  endtask

  task automatic test_sparse();
    logic [2:0] e_sel, p_sel;
    logic       e_valid, e_fs;
    do_reset();
    mask = 8'h24;
    xv   = 8'h04;
    en   = 1'b1;
    p_sel = 3'd2;
    for (int k = 0; k < 26; k++) begin
      tick();
      e_sel   = (((k / 4) % 2) == 1) ? 3'd5 : 3'd2;
      e_valid = (k >= 1);
      e_fs    = (k >= 1) && (((k - 1) % 8) == 0);
      checks++;
      if ({sel, valid, frame_start, busy} !== {e_sel, e_valid, e_fs, 1'b1}) begin
        errors++;
        $display("FAIL sparse k%0d: got sel=%0d valid=%b fs=%b busy=%b, need sel=%0d valid=%b fs=%b busy=1",
                 k, sel, valid, frame_start, busy, e_sel, e_valid, e_fs);
      end
      if (e_valid) begin
        checks++;
        if (y !== xv[p_sel]) begin
          errors++;
          $display("FAIL sparse_y k%0d: got y=%b, need %b", k, y, xv[p_sel]);
        end
      end
      p_sel = e_sel;
    end
  endtask

  // One real channel plus reserved mask bits: every advance is a wrap.
  task automatic test_single();
    logic e_valid, e_fs;
    do_reset();
    mask = 8'hC2;
    xv   = 8'h02;
    en   = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      e_valid = (k >= 1);
      e_fs    = (k >= 1) && (((k - 1) % 4) == 0);
      checks++;
      if ({sel, y, valid, frame_start, busy} !== {3'd1, e_valid, e_valid, e_fs, 1'b1}) begin
        errors++;
        $display("FAIL single k%0d: got sel=%0d y=%b valid=%b fs=%b busy=%b, need sel=1 y=%b valid=%b fs=%b busy=1",
                 k, sel, y, valid, frame_start, busy, e_valid, e_valid, e_fs);
      end
    end
  endtask

  task automatic test_reserved_only();
    do_reset();
    mask = 8'hC0;
    xv   = 8'hC0;
    en   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({sel, y, valid, frame_start, busy} !== 7'd0) begin
        errors++;
        $display("FAIL reserved k%0d: got sel=%0d y=%b valid=%b fs=%b busy=%b, need all 0",
                 k, sel, y, valid, frame_start, busy);
      end
    end
  endtask

  task automatic test_mid_abort();
    do_reset();
    mask = 8'h3F;
    xv   = 8'h08;
    en   = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if ({sel, busy} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL abort_pre: got sel=%0d busy=%b, need sel=3 busy=1", sel, busy);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({sel, valid, busy} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_e1: got sel=%0d valid=%b busy=%b, need sel=3 valid=1 busy=0", sel, valid, busy);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({sel, valid, frame_start, busy} !== {3'd3, 3'b000}) begin
        errors++;
        $display("FAIL abort_idle%0d: got sel=%0d valid=%b fs=%b busy=%b, need sel=3 valid=0 fs=0 busy=0",
                 k, sel, valid, frame_start, busy);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({sel, valid, frame_start, busy} !== {3'd0, 3'b001}) begin
      errors++;
      $display("FAIL restart_r0: got sel=%0d valid=%b fs=%b busy=%b, need sel=0 valid=0 fs=0 busy=1",
               sel, valid, frame_start, busy);
    end
    tick();
    checks++;
    if ({sel, y, valid, frame_start, busy} !== {3'd0, 4'b0111}) begin
      errors++;
      $display("FAIL restart_r1: got sel=%0d y=%b valid=%b fs=%b busy=%b, need sel=0 y=0 valid=1 fs=1 busy=1",
               sel, y, valid, frame_start, busy);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL restart_r2_fs: got fs=%b, need 0", frame_start);
    end
  endtask

  task automatic test_mid_reset_mask();
    do_reset();
    mask = 8'h3F;
    xv   = 8'h10;
    en   = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    checks++;
    if ({sel, y, valid, busy} !== {3'd4, 3'b111}) begin
      errors++;
      $display("FAIL midrst_pre: got sel=%0d y=%b valid=%b busy=%b, need sel=4 y=1 valid=1 busy=1",
               sel, y, valid, busy);
    end
    rst  = 1'b1;
    mask = 8'h3C;
    tick();
    checks++;
    if ({sel, y, valid, frame_start, busy} !== 7'd0) begin
      errors++;
      $display("FAIL midrst_zero: got sel=%0d y=%b valid=%b fs=%b busy=%b, need all 0",
               sel, y, valid, frame_start, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({sel, valid, busy} !== {3'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_r0: got sel=%0d valid=%b busy=%b, need sel=2 valid=0 busy=1", sel, valid, busy);
    end
    tick();
    checks++;
    if ({sel, valid, frame_start, busy} !== {3'd2, 3'b111}) begin
      errors++;
      $display("FAIL midrst_r1: got sel=%0d valid=%b fs=%b busy=%b, need sel=2 valid=1 fs=1 busy=1",
               sel, valid, frame_start, busy);
    end
    mask = 8'h00;
    for (int k = 2; k < 4; k++) begin
      tick();
      checks++;
      if ({sel, valid, busy} !== {3'd2, 2'b11}) begin
        errors++;
        $display("FAIL mask_clr_r%0d: got sel=%0d valid=%b busy=%b, need sel=2 valid=1 busy=1",
                 k, sel, valid, busy);
      end
    end
    tick();
    checks++;
    if ({sel, valid, busy} !== {3'd2, 2'b10}) begin
      errors++;
      $display("FAIL mask_clr_r4: got sel=%0d valid=%b busy=%b, need sel=2 valid=1 busy=0", sel, valid, busy);
    end
    tick();
    checks++;
    if ({sel, valid, frame_start, busy} !== {3'd2, 3'b000}) begin
      errors++;
      $display("FAIL mask_clr_r5: got sel=%0d valid=%b fs=%b busy=%b, need sel=2 valid=0 fs=0 busy=0",
               sel, valid, frame_start, busy);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mask = 8'h00;
    xv   = 8'h00;
    test_reset();
    test_full_scan();
    test_sparse();
    test_single();
    test_reserved_only();
    test_mid_abort();
    test_mid_reset_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_8_1_scan.md
Name: mux_8_1_scan

Overview:
Registered 8-to-1 time-division multiplexer with a round-robin scan. It is the collecting end of the 1-to-8 registered channel demux.
- Cycles through enabled channels 0..NUM_CH-1, dwelling DWELL clocks on each.
- Samples the selected input onto one serial output, with valid and frame-start strobes.
- Channel codes >= NUM_CH (6, 7 by default) are reserved and always read as 0.

Parameters:
NUM_CH, 6, number of scannable channels (1..8); codes >= NUM_CH are reserved.
DWELL, 4, clocks spent on each channel (1..255).
DWELL_W, 8, width of the dwell counter.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
en  in  1  scan enable
mask  in  8  per-channel enable; bit n enables channel n; bits >= NUM_CH ignored
x0..x7  in  1 each  channel inputs
sel  out  3  channel currently sampled (registered)
y  out  1  registered sample of the selected channel
valid  out  1  y holds a sample from an active scan
frame_start  out  1  one-cycle pulse aligned with valid on the first sample of each scan pass
busy  out  1  state == SCAN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Sets sel=0, y=0, valid=0, frame_start=0, busy=0, dwell counter=0, state=IDLE.
  - rst has priority over every other input, including mid-dwell.
- Effective mask: em = mask with bits >= NUM_CH forced to 0.
- States: IDLE, SCAN.
- IDLE -> SCAN: when en=1 and em!=0.
  - sel loads the lowest set bit of em.
  - Dwell counter loads 0.
  - The wrap flag is set, so the first pass signals frame_start.
- IDLE hold: if em==0 or en=0, the block stays in IDLE, sel is held, busy=0.
- SCAN, dwell counting:
  - The counter increments each clock.
  - At count DWELL-1, sel advances to the next set bit of em, searching upward from sel+1 modulo NUM_CH, and the counter clears.
- Wrap:
  - The wrap flag is set when the next channel <= the current channel.
  - With a single enabled channel, every advance is a wrap.
- mask timing:
  - mask is sampled only at the advance point; the current dwell always completes.
  - If em==0 at the advance point, the block goes to IDLE.
- en=0 in SCAN: IDLE on the next edge, abandoning the dwell; sel holds its last value.
- Output pipeline, one cycle after sel:
  - y <= (sel < NUM_CH) ? x[sel] : 0.
  - valid <= (state==SCAN).
  - frame_start <= (state==SCAN && counter==0 && wrap flag); the wrap flag then clears.
- Latency: y at edge t+1 equals x[sel] at edge t. valid and frame_start carry the same one-cycle latency relative to sel.
- Leaving SCAN: valid falls one cycle after busy falls.
- Reserved codes: y=0 even if the corresponding x input is high.
- en and em rising together in the same cycle: the first sel is presented on the next edge, and the first valid one edge later.

Decomposition:
- Shared package (mux_scan_pkg):
  - CH_W=3, NUM_CH_MAX=8.
  - State enum {IDLE, SCAN}.
  - Function lowest_set(em).
- Sub-module rr_next_ch (combinational).
  - Inputs: current sel, em.
  - Outputs: next channel, wrap flag, none_set.
  - Covers the wraparound priority search; unit-tested separately.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, mask=8'hFF, x all 1 -> sel=0, y=0, valid=0, frame_start=0, busy=0 throughout.
2. Full scan: mask=8'h3F, en=1, x0=1, x3=1, others 0.
   - sel sequence 0,0,0,0,1,...,5,5,5,5,0.
   - y=1 during the 4 cycles lagging sel=0 and sel=3 by one cycle.
   - frame_start pulses every 24 cycles.
3. Sparse mask: mask=8'h24 (ch2, ch5) -> sel 2,2,2,2,5,5,5,5,2...; frame_start every 8 cycles, coinciding with the first ch2 sample.
4. Reserved only: mask=8'hC0, en=1, x6=x7=1 -> remains IDLE; busy=0, valid=0, y=0 indefinitely.
5. Mid-dwell abort: en drops on the 2nd dwell cycle of ch3.
   - Next edge: busy=0. Following edge: valid=0.
   - en re-raised with mask=8'h3F -> scan restarts at sel=0, and frame_start pulses on the first valid sample.
6. Mid-scan reset and mask change:
   - rst for 1 cycle during ch4 -> all outputs 0 next edge; after release the scan restarts at the lowest enabled channel.
   - mask cleared to 8'h00 during a dwell -> that dwell completes its 4 cycles, then IDLE.
